// File: rtl/seven_segment_scan_decoder.sv
// Receive side of the character-to-seven-segment path: samples a scanned,
// active-low 5-digit segment bus and recovers the five 3-bit character codes.
module seven_segment_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [2:0] dig_sel,
  input  logic [6:0] seg_n,
  input  logic       err_clr,
  output logic [2:0] U,
  output logic [2:0] V,
  output logic [2:0] W,
  output logic [2:0] X,
  output logic [2:0] Y,
  output logic [4:0] digit_upd,
  output logic       frame_done,
  output logic       code_err,
  output logic       sel_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LP_STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [2:0]       LP_BLANK  = 3'b100;

  // Returns {legal, code}; illegal patterns return legal=0 and a don't-care code.
  function automatic logic [3:0] decode_seg(input logic [6:0] seg);
    logic [3:0] res;
    case (seg)
      7'b0001001: res = {1'b1, 3'b000};
      7'b0000110: res = {1'b1, 3'b001};
      7'b1000111: res = {1'b1, 3'b010};
      7'b1000000: res = {1'b1, 3'b011};
      7'b1111111: res = {1'b1, 3'b100};
      default:    res = {1'b0, 3'b000};
    endcase
    return res;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cap_sel;
  logic [6:0]       r_cap_seg;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_same;
  logic             w_new;
  logic             w_capture;
  logic             w_accept;
  logic             w_sel_bad;
  logic [3:0]       w_dec;
  logic             w_legal;
  logic [4:0]       w_upd_nxt;
  logic [4:0]       w_mask_or;
  logic             w_frame;

  logic [2:0]       r_chr [0:4];
  logic [4:0]       r_mask;
  logic [4:0]       r_upd;
  logic             r_frame;
  logic             r_code_err;
  logic             r_sel_err;

  assign w_same    = strobe && (dig_sel == r_cap_sel) && (seg_n == r_cap_seg);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_dec     = decode_seg(seg_n);
  assign w_legal   = w_dec[3];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_new       = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    w_sel_bad   = 1'b0;
    case (r_state)
      S_TRACK: begin
        if (!strobe) begin
          w_state_nxt = S_IDLE;
        end else if (w_same) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LP_STABLE) begin
            w_accept    = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else begin
          w_new = 1'b1;
        end
      end
      S_HOLD: begin
        if (!strobe) begin
          w_state_nxt = S_IDLE;
        end else if (!w_same) begin
          w_new = 1'b1;
        end
      end
      default: begin
        if (strobe) begin
          w_new = 1'b1;
        end
      end
    endcase
    // A fresh sample either starts a new stability run or flags a bad select.
    if (w_new) begin
      if (dig_sel > 3'd4) begin
        w_sel_bad   = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_capture   = 1'b1;
        w_cnt_nxt   = CNT_W'(1);
        w_state_nxt = S_TRACK;
        if (LP_STABLE == CNT_W'(1)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
    end
  end

  assign w_upd_nxt = (w_accept && w_legal) ? (5'b00001 << dig_sel) : 5'b00000;
  assign w_mask_or = r_mask | w_upd_nxt;
  assign w_frame   = (w_mask_or == 5'b11111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cap_sel <= 3'd0;
      r_cap_seg <= 7'd0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_cap_sel <= dig_sel;
        r_cap_seg <= seg_n;
      end
    end
  end

  // Accept stage: character registers, frame tracking and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        r_chr[i] <= LP_BLANK;
      end
      r_mask     <= 5'd0;
      r_upd      <= 5'd0;
      r_frame    <= 1'b0;
      r_code_err <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_upd_nxt[i]) begin
          r_chr[i] <= w_dec[2:0];
        end
      end
      r_mask     <= w_frame ? 5'd0 : w_mask_or;
      r_upd      <= w_upd_nxt;
      r_frame    <= w_frame;
      r_code_err <= (r_code_err & ~err_clr) | (w_accept & ~w_legal);
      r_sel_err  <= (r_sel_err & ~err_clr) | w_sel_bad;
    end
  end

  assign U          = r_chr[0];
  assign V          = r_chr[1];
  assign W          = r_chr[2];
  assign X          = r_chr[3];
  assign Y          = r_chr[4];
  assign digit_upd  = r_upd;
  assign frame_done = r_frame;
  assign code_err   = r_code_err;
  assign sel_err    = r_sel_err;

endmodule

// File: doc/seven_segment_scan_decoder.md
Name: seven_segment_scan_decoder

Overview:
- Receive side of the character-to-seven-segment path: samples a time-multiplexed, active-low 5-digit segment bus and recovers the five 3-bit character codes.
- Outputs U, V, W, X, Y match the character inputs of the 5-to-1 character mux, so a display driver can be checked end-to-end.
- Sits between a scanning display driver (or its model) and checker/loopback logic.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted; legal range 1–255.
- CNT_W, 8: stability counter width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- strobe  input  1  digit-valid qualifier from the scanning driver
- dig_sel  input  3  index of the digit currently driven, 0..4 (0=U … 4=Y)
- seg_n  input  7  segment pattern, active-low, bit0=a … bit6=g
- err_clr  input  1  synchronous clear of the sticky error flags
- U, V, W, X, Y  output  3 each  recovered character codes
- digit_upd  output  5  one-hot, 1-cycle pulse when a digit register is written
- frame_done  output  1  1-cycle pulse when all five digits have been accepted since the last pulse
- code_err  output  1  sticky flag: an accepted pattern was not a legal character
- sel_err  output  1  sticky flag: strobe seen with dig_sel > 4

Behaviour:
- Reset (async, rst=1):
  - U..Y = 3'b100 (blank).
  - digit_upd = 0, frame_done = 0, code_err = 0, sel_err = 0.
  - Stability counter, captured pattern/index and frame mask = 0.
  - Reset mid-frame discards the partial frame.
- Pattern decode (combinational, on the stable sample):
  - 7'b0001001 -> 000 (H)
  - 7'b0000110 -> 001 (E)
  - 7'b1000111 -> 010 (L)
  - 7'b1000000 -> 011 (O)
  - 7'b1111111 -> 100 (blank)
  - Any other pattern is illegal.
- Stability FSM, states IDLE, TRACK, HOLD:
  - IDLE:
    - strobe=1 and dig_sel<=4: capture {dig_sel, seg_n}, cnt=1, go to TRACK.
    - strobe=1 and dig_sel>4: set sel_err, stay in IDLE.
  - TRACK:
    - strobe=1 with identical {dig_sel, seg_n}: cnt++.
    - When cnt reaches STABLE_CYCLES, accept the digit and go to HOLD.
    - Any mismatch: recapture the new value, cnt=1, stay in TRACK (dig_sel>4 sets sel_err and goes to IDLE instead).
    - strobe=0: go to IDLE.
  - HOLD:
    - Same digit still present: stay, no further updates.
    - strobe=0 or a change of {dig_sel, seg_n}: treat like IDLE on that cycle (new value captured, cnt=1).
  - With STABLE_CYCLES=1, acceptance occurs on the capture cycle itself.
- Accept action (registered, visible the cycle after the accepting sample):
  - Legal pattern: write the code into the register selected by dig_sel, pulse digit_upd[dig_sel], set frame mask bit.
  - Illegal pattern: register unchanged, no digit_upd, code_err <= 1, mask bit not set.
- Latency: first stable sample at cycle t -> register update and digit_upd at t+STABLE_CYCLES.
- Frame:
  - When the mask reaches 5'b11111, frame_done pulses in the same cycle as the last digit_upd and the mask clears.
  - Re-accepting an already-masked digit updates its register but does not affect frame_done.
- Flags:
  - err_clr=1 clears code_err/sel_err next cycle.
  - Simultaneous clear and new error: the error wins (flag stays 1).
- digit_upd and frame_done are never asserted for more than one cycle per acceptance.

Test Plan:
- Reset: assert rst mid-TRACK -> all outputs at reset values immediately; U..Y = 100; no frame_done after release until five new digits.
- Nominal frame (STABLE_CYCLES=4): drive H,E,L,L,O on digits 0..4, 6 cycles each -> U=000, V=001, W=010, X=010, Y=011; digit_upd pulses 00001..10000; one frame_done with the Y update.
- Glitch rejection: digit 2 shows 7'b1000111 for 3 cycles, then 7'b0000110 for 4 -> W=001 only; exactly one digit_upd[2].
- Illegal pattern: digit 1 holds 7'b0101010 for 4 cycles -> V unchanged, code_err=1, no frame_done; err_clr -> code_err=0 next cycle.
- Bad select: strobe with dig_sel=6 -> sel_err=1, no register or mask change; err_clr together with another dig_sel=7 -> sel_err stays 1.
- Hold/no-repeat: digit 4 blank (7'b1111111) held for 20 cycles -> Y=100, single digit_upd[4] pulse; strobe low 1 cycle then same pattern for 4 cycles -> second pulse.
